// File: rtl/venus_soc_pkg.sv
// rtl/venus_soc_pkg.sv - AXI4 bus widths and request/response channel bundles
package venus_soc_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 512;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_ID_W   = 8;

    typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
    typedef logic [AXI_DATA_W-1:0] axi_data_t;
    typedef logic [AXI_STRB_W-1:0] axi_strb_t;
    typedef logic [AXI_ID_W-1:0]   axi_id_t;

    // Master -> slave: AW, W, AR channels plus B/R ready
    typedef struct packed {
        axi_id_t    awid;
        axi_addr_t  awaddr;
        logic [7:0] awlen;
        logic [2:0] awsize;
        logic [1:0] awburst;
        logic       awvalid;
        axi_data_t  wdata;
        axi_strb_t  wstrb;
        logic       wlast;
        logic       wvalid;
        logic       bready;
        axi_id_t    arid;
        axi_addr_t  araddr;
        logic [7:0] arlen;
        logic [2:0] arsize;
        logic [1:0] arburst;
        logic       arvalid;
        logic       rready;
    } axi_req_t;

    // Slave -> master: AW/W/AR ready plus B and R channels
    typedef struct packed {
        logic       awready;
        logic       wready;
        axi_id_t    bid;
        logic [1:0] bresp;
        logic       bvalid;
        logic       arready;
        axi_id_t    rid;
        axi_data_t  rdata;
        logic [1:0] rresp;
        logic       rlast;
        logic       rvalid;
    } axi_resp_t;

endpackage

// File: rtl/dma_axi_sram_slave.sv
// rtl/dma_axi_sram_slave.sv - AXI4 slave backed by a byte-strobed register-array memory
//
// Ports:
//   clk        - clock
//   rstn       - synchronous active-low reset
//   axi_req_i  - AXI master request (AW/W/AR payloads, valids, B/R ready)
//   axi_resp_o - AXI slave response (AW/W/AR ready, B/R payloads, valids)
//
// Independent single-outstanding read and write engines. Accesses outside
// [MEM_BASE, MEM_BASE+MEM_BYTES) return DECERR; write beat-count mismatches
// against awlen return SLVERR.
module dma_axi_sram_slave
    import venus_soc_pkg::*;
#(
    parameter axi_addr_t   MEM_BASE  = '0,
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic      clk,
    input  logic      rstn,
    input  axi_req_t  axi_req_i,
    output axi_resp_t axi_resp_o
);

    localparam int unsigned BUS_BYTES = AXI_STRB_W;
    localparam int unsigned OFF_LSB   = $clog2(BUS_BYTES);
    localparam int unsigned WORDS     = MEM_BYTES / BUS_BYTES;
    localparam int unsigned IDX_W     = $clog2(WORDS);

    axi_data_t mem [WORDS];

    // Offset is taken modulo the address width so addresses below MEM_BASE
    // wrap to huge offsets and fall out of the window.
    function automatic logic in_window(input axi_addr_t a);
        axi_addr_t off;
        off = a - MEM_BASE;
        return off < axi_addr_t'(MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input axi_addr_t a);
        axi_addr_t off;
        off = a - MEM_BASE;
        return IDX_W'(off >> OFF_LSB);
    endfunction

    // FIXED bursts hold the address; INCR and WRAP both step by the beat size.
    function automatic axi_addr_t next_addr(input axi_addr_t a, input logic [2:0] size,
                                            input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (axi_addr_t'(1) << size);
    endfunction

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_BURST} r_state_t;

    r_state_t   r_state, r_state_nxt;
    axi_addr_t  r_addr;
    logic [7:0] r_len, r_beat;
    logic [2:0] r_size;
    logic [1:0] r_burst;
    axi_id_t    r_id;

    logic       arready, rvalid, rlast;
    logic [1:0] rresp;
    axi_data_t  rdata;
    axi_id_t    rid;
    logic       ar_hs, r_hs, r_in_win;

    assign ar_hs    = axi_req_i.arvalid && arready;
    assign r_hs     = rvalid && axi_req_i.rready;
    assign r_in_win = in_window(r_addr);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_id    <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_addr  <= axi_req_i.araddr;
                r_len   <= axi_req_i.arlen;
                r_size  <= axi_req_i.arsize;
                r_burst <= axi_req_i.arburst;
                r_id    <= axi_req_i.arid;
                r_beat  <= '0;
            end else if (r_hs) begin
                r_beat <= r_beat + 8'd1;
                r_addr <= next_addr(r_addr, r_size, r_burst);
            end
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_BURST;
            R_BURST: if (r_hs && rlast) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Payload is forced to zero outside a burst so idle/reset outputs are clean.
    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = 2'b00;
        rdata   = '0;
        rid     = '0;
        case (r_state)
            R_IDLE: arready = 1'b1;
            R_BURST: begin
                rvalid = 1'b1;
                rlast  = (r_beat == r_len);
                rid    = r_id;
                rresp  = r_in_win ? 2'b00 : 2'b11;
                rdata  = r_in_win ? mem[word_idx(r_addr)] : '0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t   w_state, w_state_nxt;
    axi_addr_t  w_addr;
    logic [7:0] w_len, w_beat;
    logic [2:0] w_size;
    logic [1:0] w_burst;
    axi_id_t    w_id;
    logic       err_decerr, err_slverr;

    logic       awready, wready, bvalid;
    logic [1:0] bresp;
    axi_id_t    bid;
    logic       aw_hs, w_hs, b_hs, w_in_win;

    assign aw_hs    = axi_req_i.awvalid && awready;
    assign w_hs     = axi_req_i.wvalid && wready;
    assign b_hs     = bvalid && axi_req_i.bready;
    assign w_in_win = in_window(w_addr);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state    <= W_IDLE;
            w_addr     <= '0;
            w_len      <= '0;
            w_beat     <= '0;
            w_size     <= '0;
            w_burst    <= '0;
            w_id       <= '0;
            err_decerr <= 1'b0;
            err_slverr <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_addr     <= axi_req_i.awaddr;
                w_len      <= axi_req_i.awlen;
                w_size     <= axi_req_i.awsize;
                w_burst    <= axi_req_i.awburst;
                w_id       <= axi_req_i.awid;
                w_beat     <= '0;
                err_decerr <= 1'b0;
                err_slverr <= 1'b0;
            end else if (w_hs) begin
                w_beat <= w_beat + 8'd1;
                w_addr <= next_addr(w_addr, w_size, w_burst);
                if (!w_in_win)
                    err_decerr <= 1'b1;
                // Early wlast, or the final expected beat arriving without wlast
                if (axi_req_i.wlast != (w_beat == w_len))
                    err_slverr <= 1'b1;
            end
        end
    end

    // Memory is deliberately outside the reset domain; only gated so a beat
    // presented during the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rstn && w_hs && w_in_win) begin
            for (int i = 0; i < AXI_STRB_W; i++) begin
                if (axi_req_i.wstrb[i])
                    mem[word_idx(w_addr)][8*i +: 8] <= axi_req_i.wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && axi_req_i.wlast) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        bid     = '0;
        case (w_state)
            W_IDLE: awready = 1'b1;
            W_DATA: wready = 1'b1;
            W_RESP: begin
                bvalid = 1'b1;
                bid    = w_id;
                bresp  = err_decerr ? 2'b11 : (err_slverr ? 2'b10 : 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        axi_resp_o         = '0;
        axi_resp_o.awready = awready;
        axi_resp_o.wready  = wready;
        axi_resp_o.bid     = bid;
        axi_resp_o.bresp   = bresp;
        axi_resp_o.bvalid  = bvalid;
        axi_resp_o.arready = arready;
        axi_resp_o.rid     = rid;
        axi_resp_o.rdata   = rdata;
        axi_resp_o.rresp   = rresp;
        axi_resp_o.rlast   = rlast;
        axi_resp_o.rvalid  = rvalid;
    end

endmodule
